// File: rtl/bram_boot_sequencer.sv
// Boot sequencer for the single-cycle core: streams a program image into the
// byte-enabled BRAM while the core is held in reset, releases the core with a
// one-cycle start pulse, then counts run cycles until a halt PC or the timeout.
module bram_boot_sequencer #(
  parameter int unsigned               DATA_WIDTH       = 32,
  parameter int unsigned               ADDRESS_BITS     = 32,
  parameter int unsigned               MEM_ADDRESS_BITS = 14,
  parameter logic [ADDRESS_BITS-1:0]   HALT_PC_0        = 32'h000000a8,
  parameter logic [ADDRESS_BITS-1:0]   HALT_PC_1        = 32'h000000ac,
  parameter logic [31:0]               TIMEOUT_CYCLES   = 32'd1000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          boot_req,
  input  logic [MEM_ADDRESS_BITS-1:0]   load_base,
  input  logic [MEM_ADDRESS_BITS:0]     load_length,
  input  logic [ADDRESS_BITS-1:0]       entry_address,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          mem_write,
  output logic [MEM_ADDRESS_BITS-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0]       mem_byte_en,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          core_reset,
  output logic                          core_start,
  output logic [ADDRESS_BITS-1:0]       program_address,
  input  logic [ADDRESS_BITS-1:0]       PC,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic [31:0]                   cycle_count
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [MEM_ADDRESS_BITS-1:0] PTR_ONE  = {{(MEM_ADDRESS_BITS-1){1'b0}}, 1'b1};
  localparam logic [MEM_ADDRESS_BITS:0]   LEN_ZERO = '0;
  localparam logic [MEM_ADDRESS_BITS:0]   LEN_ONE  = {{MEM_ADDRESS_BITS{1'b0}}, 1'b1};
  localparam logic [31:0]                 LAST_CNT = TIMEOUT_CYCLES - 32'd1;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, START, RUN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [MEM_ADDRESS_BITS-1:0]   ptr_q, ptr_d;
  logic [MEM_ADDRESS_BITS:0]     remaining_q, remaining_d;
  logic                          mem_write_q, mem_write_d;
  logic [MEM_ADDRESS_BITS-1:0]   mem_address_q, mem_address_d;
  logic [BE_WIDTH-1:0]           mem_byte_en_q, mem_byte_en_d;
  logic [DATA_WIDTH-1:0]         mem_data_q, mem_data_d;
  logic [ADDRESS_BITS-1:0]       program_address_q, program_address_d;
  logic [31:0]                   cycle_count_q, cycle_count_d;
  logic                          timeout_q, timeout_d;
  logic                          s_ready_q, s_ready_d;
  logic                          core_reset_q, core_reset_d;
  logic                          core_start_q, core_start_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          halt_hit;

  assign halt_hit = (PC == HALT_PC_0) || (PC == HALT_PC_1);

  // Next-state and next-output logic; status outputs are decoded from the
  // next state so every output comes straight off a flop.
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    remaining_d       = remaining_q;
    mem_write_d       = 1'b0;
    mem_byte_en_d     = '0;
    mem_address_d     = mem_address_q;
    mem_data_d        = mem_data_q;
    program_address_d = program_address_q;
    cycle_count_d     = cycle_count_q;
    timeout_d         = timeout_q;

    case (state_q)
      IDLE, DONE: begin
        if (boot_req) begin
          ptr_d             = load_base;
          remaining_d       = load_length;
          program_address_d = entry_address;
          state_d           = (load_length == LEN_ZERO) ? HOLD : LOAD;
        end
      end
      LOAD: begin
        if (s_valid && s_ready_q) begin
          mem_write_d   = 1'b1;
          mem_byte_en_d = '1;
          mem_address_d = ptr_q;
          mem_data_d    = s_data;
          ptr_d         = ptr_q + PTR_ONE;
          remaining_d   = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        state_d = START;
      end
      START: begin
        cycle_count_d = '0;
        timeout_d     = 1'b0;
        state_d       = RUN;
      end
      RUN: begin
        // A halt PC takes priority over the timeout in the same cycle.
        if (halt_hit) begin
          state_d = DONE;
        end else if (cycle_count_q == LAST_CNT) begin
          timeout_d     = 1'b1;
          cycle_count_d = cycle_count_q + 32'd1;
          state_d       = DONE;
        end else begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d    = (state_d == LOAD);
    core_reset_d = !((state_d == START) || (state_d == RUN));
    core_start_d = (state_d == START);
    busy_d       = (state_d == LOAD) || (state_d == HOLD) ||
                   (state_d == START) || (state_d == RUN);
    done_d       = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q           <= IDLE;
      ptr_q             <= '0;
      remaining_q       <= '0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_byte_en_q     <= '0;
      mem_data_q        <= '0;
      program_address_q <= '0;
      cycle_count_q     <= '0;
      timeout_q         <= 1'b0;
      s_ready_q         <= 1'b0;
      core_reset_q      <= 1'b1;
      core_start_q      <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      remaining_q       <= remaining_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_byte_en_q     <= mem_byte_en_d;
      mem_data_q        <= mem_data_d;
      program_address_q <= program_address_d;
      cycle_count_q     <= cycle_count_d;
      timeout_q         <= timeout_d;
      s_ready_q         <= s_ready_d;
      core_reset_q      <= core_reset_d;
      core_start_q      <= core_start_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_byte_en     = mem_byte_en_q;
  assign mem_data        = mem_data_q;
  assign core_reset      = core_reset_q;
  assign core_start      = core_start_q;
  assign program_address = program_address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout         = timeout_q;
  assign cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_bram_boot_sequencer.sv
// Bench for bram_boot_sequencer: a table of boot/run scenarios plus hand-written
// reset-abort sequences; BRAM writes are checked against a scoreboard queue.
module tb_bram_boot_sequencer;

  localparam int TMO = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_req;
  logic [13:0] load_base;
  logic [14:0] load_length;
  logic [31:0] entry_address;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mem_write;
  logic [13:0] mem_address;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data;
  logic        core_reset;
  logic        core_start;
  logic [31:0] program_address;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [13:0] base;
    logic [14:0] len;
    logic [31:0] entry;
    bit          toggle;
    int          halt_cycle;   // 0: PC never matches
    logic [31:0] halt_pc;
    logic [31:0] exp_count;
    bit          exp_timeout;
  } vec_t;
  vec_t vecs[4];

  bram_boot_sequencer #(
    .TIMEOUT_CYCLES(32'd60)
  ) dut (
    .clock           (clk),
    .reset           (rst_n),
    .boot_req        (boot_req),
    .load_base       (load_base),
    .load_length     (load_length),
    .entry_address   (entry_address),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_byte_en     (mem_byte_en),
    .mem_data        (mem_data),
    .core_reset      (core_reset),
    .core_start      (core_start),
    .program_address (program_address),
    .PC              (pc),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout),
    .cycle_count     (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_s_ready"},    64'(s_ready), 64'd0);
    check({tag, "_mem_write"},  64'(mem_write), 64'd0);
    check({tag, "_byte_en"},    64'(mem_byte_en), 64'd0);
    check({tag, "_core_start"}, 64'(core_start), 64'd0);
    check({tag, "_busy"},       64'(busy), 64'd0);
    check({tag, "_done"},       64'(done), 64'd0);
    check({tag, "_timeout"},    64'(timeout), 64'd0);
    check({tag, "_mem_addr"},   64'(mem_address), 64'd0);
    check({tag, "_mem_data"},   64'(mem_data), 64'd0);
    check({tag, "_cycle_cnt"},  64'(cycle_count), 64'd0);
    check({tag, "_prog_addr"},  64'(program_address), 64'd0);
  endtask

  // Write monitor: every registered BRAM write must match the next expected one.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (mem_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(mem_write), 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_address), 64'(e.addr));
          check("wr_data", 64'(mem_data), 64'(e.data));
          check("wr_byte_en", 64'(mem_byte_en), 64'hF);
          $display("write addr=%h data=%h be=%h", mem_address, mem_data, mem_byte_en);
        end
      end else begin
        check("byte_en_idle", 64'(mem_byte_en), 64'd0);
      end
    end
  end

  // Issue boot_req and stream len words; returns in HOLD.
  task automatic boot_and_load(input logic [13:0] base, input logic [14:0] len,
                               input logic [31:0] entry, input bit toggle, input int tag);
    logic [13:0] ptr;
    ptr           = base;
    boot_req      = 1'b1;
    load_base     = base;
    load_length   = len;
    entry_address = entry;
    step();
    boot_req = 1'b0;
    check("done_cleared", 64'(done), 64'd0);
    check("busy_after_boot", 64'(busy), 64'd1);
    for (int w = 0; w < int'(len); w++) begin
      if (toggle && w > 0) begin
        s_valid = 1'b0;
        s_data  = 32'hDEADBEEF;
        step();
        check("s_ready_gap", 64'(s_ready), 64'd1);
      end
      check("s_ready_load", 64'(s_ready), 64'd1);
      check("core_reset_load", 64'(core_reset), 64'd1);
      s_valid = 1'b1;
      s_data  = (32'h11111111 * (w + 1)) ^ (32'(tag) << 28);
      exp_q.push_back('{addr: ptr, data: s_data});
      ptr = ptr + 14'd1;
      step();
    end
    s_valid = 1'b0;
    s_data  = 32'h0;
    // HOLD
    check("hold_s_ready", 64'(s_ready), 64'd0);
    check("hold_core_reset", 64'(core_reset), 64'd1);
    check("hold_core_start", 64'(core_start), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int last;
    boot_and_load(v.base, v.len, v.entry, v.toggle, idx);
    step();
    // START
    check("start_pulse", 64'(core_start), 64'd1);
    check("start_core_reset", 64'(core_reset), 64'd0);
    check("start_prog_addr", 64'(program_address), 64'(v.entry));
    last = (v.halt_cycle != 0) ? v.halt_cycle : TMO;
    for (int n = 1; n <= last; n++) begin
      step();
      if (n == 1) begin
        check("start_one_cycle", 64'(core_start), 64'd0);
        check("run_core_reset", 64'(core_reset), 64'd0);
      end else begin
        check("run_not_done", 64'(done), 64'd0);
      end
      pc = (n == v.halt_cycle) ? v.halt_pc : (32'h200 + 32'(n) * 32'd4);
    end
    step();
    pc = 32'h0;
    check("end_done", 64'(done), 64'd1);
    check("end_timeout", 64'(timeout), 64'(v.exp_timeout));
    check("end_cycle_count", 64'(cycle_count), 64'(v.exp_count));
    check("end_core_reset", 64'(core_reset), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    $display("vec %0d: base=%h len=%0d entry=%h done=%b timeout=%b cycle_count=%0d",
             idx, v.base, v.len, v.entry, done, timeout, cycle_count);
    step();
    check("done_held", 64'(done), 64'd1);
    check("count_held", 64'(cycle_count), 64'(v.exp_count));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 14'h3FFE, len: 15'd4, entry: 32'h0,   toggle: 1'b0,
                halt_cycle: 50, halt_pc: 32'ha8, exp_count: 32'd49, exp_timeout: 1'b0};
    vecs[1] = '{base: 14'h3FFE, len: 15'd4, entry: 32'h40,  toggle: 1'b1,
                halt_cycle: 0,  halt_pc: 32'h0,  exp_count: 32'd60, exp_timeout: 1'b1};
    vecs[2] = '{base: 14'h0100, len: 15'd0, entry: 32'h100, toggle: 1'b0,
                halt_cycle: 60, halt_pc: 32'hac, exp_count: 32'd59, exp_timeout: 1'b0};
    vecs[3] = '{base: 14'h0010, len: 15'd3, entry: 32'h80,  toggle: 1'b1,
                halt_cycle: 1,  halt_pc: 32'ha8, exp_count: 32'd0,  exp_timeout: 1'b0};

    rst_n = 1'b0; boot_req = 1'b0; load_base = '0; load_length = '0;
    entry_address = '0; s_data = '0; s_valid = 1'b0; pc = '0;
    repeat (3) step();
    check_reset_vals("por");
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    check_reset_vals("idle");

    // Reset in the middle of LOAD: two words land, then nothing more.
    boot_req = 1'b1; load_base = 14'h0020; load_length = 15'd4; entry_address = 32'h55;
    step();
    boot_req = 1'b0;
    for (int w = 0; w < 2; w++) begin
      s_valid = 1'b1;
      s_data  = 32'hA0000000 + 32'(w);
      exp_q.push_back('{addr: 14'h0020 + 14'(w), data: s_data});
      step();
    end
    rst_n = 1'b0;
    s_data = 32'hBADBAD00;
    step();
    $display("reset in LOAD applied");
    check_reset_vals("rst_load");
    rst_n = 1'b1;
    s_valid = 1'b0;
    repeat (4) step();
    check("rst_load_queue", 64'(exp_q.size()), 64'd0);
    check("rst_load_idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Reset in RUN, from DONE via a zero-length boot.
    boot_and_load(14'h0, 15'd0, 32'h300, 1'b0, 9);
    step();
    check("rr_start", 64'(core_start), 64'd1);
    step();
    pc = 32'h204;
    step();
    check("rr_busy_run", 64'(busy), 64'd1);
    check("rr_count_run", 64'(cycle_count), 64'd1);
    rst_n = 1'b0;
    step();
    $display("reset in RUN applied");
    check_reset_vals("rst_run");
    rst_n = 1'b1;
    pc = 32'h0;
    repeat (2) step();
    check("rst_run_idle_busy", 64'(busy), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_boot_sequencer.md
# bram_boot_sequencer

Controller that owns the single-cycle core and its byte-enabled dual-port BRAM across one benchmark run. It streams a program image into the BRAM through the byte-enable write path and holds the core in reset meanwhile. It then pulses `start` with the entry address, watches the core PC for the halt addresses, and reports the run length in cycles plus a timeout flag. It sits between the program source (debug/UART link) and the core top, replacing bench-side BRAM preloading and cycle counting.

## Interface
- DATA_WIDTH, 32, memory word width; byte enables are DATA_WIDTH/8 bits wide
- ADDRESS_BITS, 32, core PC and program address width
- MEM_ADDRESS_BITS, 14, BRAM word-address width
- HALT_PC_0, 32'h000000a8, first halt PC
- HALT_PC_1, 32'h000000ac, second halt PC
- TIMEOUT_CYCLES, 32'd1000000, RUN-cycle limit; must be ≥1
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low
- boot_req  in  1  starts a sequence; sampled only in IDLE or DONE
- load_base  in  MEM_ADDRESS_BITS  first BRAM word address; latched on accepted boot_req
- load_length  in  MEM_ADDRESS_BITS+1  words to load (0..2**MEM_ADDRESS_BITS); latched
- entry_address  in  ADDRESS_BITS  core start address; latched
- s_data  in  DATA_WIDTH  program word
- s_valid  in  1  s_data valid
- s_ready  out  1  sequencer accepts a word
- mem_write  out  1  BRAM write strobe, registered
- mem_address  out  MEM_ADDRESS_BITS  BRAM word address, registered
- mem_byte_en  out  DATA_WIDTH/8  all ones when mem_write=1, else 0
- mem_data  out  DATA_WIDTH  write data, registered
- core_reset  out  1  active-high reset to the core
- core_start  out  1  one-cycle start pulse
- program_address  out  ADDRESS_BITS  to the core; the latched entry_address
- PC  in  ADDRESS_BITS  core fetch PC
- busy  out  1  high in LOAD, HOLD, START, RUN
- done  out  1  run finished
- timeout  out  1  run ended by the limit rather than a halt PC
- cycle_count  out  32  RUN cycles before the halt; frozen in DONE

## Operation
- States: IDLE, LOAD, HOLD, START, RUN, DONE.
- IDLE: core_reset=1, s_ready=0, busy=0.
  - boot_req=1 latches base, length, and entry address, then moves to LOAD.
  - If load_length=0, it moves to HOLD instead.
- LOAD: s_ready=1, core_reset=1.
  - Each cycle with s_valid&&s_ready registers mem_write=1, mem_address=current pointer, mem_data=s_data, and mem_byte_en all ones.
  - The pointer then increments modulo 2**MEM_ADDRESS_BITS, so it wraps from all-ones to 0.
  - Cycles without a handshake register mem_write=0 and mem_byte_en=0.
  - The handshake that accepts the last word moves the FSM to HOLD.
- HOLD: one cycle; core_reset=1, s_ready=0. The final registered write lands here, before the core leaves reset.
- START: one cycle; core_reset=0, core_start=1, cycle counter cleared to 0, timeout cleared.
- RUN: core_reset=0.
  - If PC==HALT_PC_0 or PC==HALT_PC_1, go to DONE with cycle_count unchanged.
  - Else if counter==TIMEOUT_CYCLES-1, set timeout=1, increment the counter, and go to DONE.
  - Else increment the counter.
  - A halt match wins over the timeout in the same cycle.
- DONE: done=1, core_reset=1 (core frozen), cycle_count and timeout held.
  - boot_req=1 clears done and restarts exactly as from IDLE.
- boot_req is ignored in LOAD through RUN.
- program_address always outputs the latched entry address.

## Timing
- Reset values: FSM=IDLE; core_reset=1; s_ready, mem_write, mem_byte_en, core_start, busy, done, timeout all 0; mem_address=0, mem_data=0, cycle_count=0, program_address=0.
- Reset low mid-sequence: next edge returns everything to reset values; a partial load is abandoned with no further writes.
- Write latency: BRAM write appears 1 cycle after its handshake.
- Minimum boot_req-to-core_start latency: load_length+2 cycles with s_valid held high.
- core_start goes high exactly 1 cycle after HOLD and stays high for exactly 1 cycle.
- cycle_count = number of RUN cycles whose PC did not match; 0 if the first RUN cycle already matches.
- done rises the cycle after the matching RUN cycle.
- On timeout, cycle_count=TIMEOUT_CYCLES.

## Test plan
- Load 4 words (11111111..44444444) at base 0x3FFE with s_valid always high -> writes to addresses 3FFE, 3FFF, 0000, 0001 with byte_en=4'hF; core_start pulses once, 6 cycles after boot_req.
- Same load with s_valid toggling every other cycle -> exactly 4 writes, no duplicates, s_ready low in HOLD.
- load_length=0, entry_address=0x100 -> IDLE→HOLD→START with program_address=0x100 and no mem_write.
- Model PC reaching 0xa8 on the 50th RUN cycle -> cycle_count=49, done=1, timeout=0, core_reset=1 on the next cycle.
- TIMEOUT_CYCLES=8 with PC never matching -> done=1, timeout=1, cycle_count=8; PC=0xac on the 8th RUN cycle instead -> timeout=0, cycle_count=7.
- reset low for 1 cycle in the middle of LOAD, and again in RUN -> all outputs at reset values on the next cycle, no further writes; boot_req in DONE starts a clean rerun.
